// File: rtl/except_commit.sv
// Trap/mret commit sequencer at the end of the exception pipeline: drives the single CSR
// write port through mepc/mcause/mtval/mstatus, holds the pipe flushed, then redirects fetch.
module except_commit #(
   parameter int XLEN        = 64,
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   // Flattened exception pack, MSB first: {except, epc, ecause, etval}
   input  logic [3*XLEN:0]   except_i,
   input  logic              mret_i,
   input  logic [XLEN-1:0]   mtvec_i,
   input  logic [XLEN-1:0]   mepc_i,
   input  logic [XLEN-1:0]   mstatus_i,
   output logic              csr_we_o,
   output logic [11:0]       csr_waddr_o,
   output logic [XLEN-1:0]   csr_wdata_o,
   output logic              flush_o,
   output logic              stall_o,
   output logic              redirect_o,
   output logic [XLEN-1:0]   redirect_pc_o
);

   localparam logic [11:0]     CSR_MSTATUS = 12'h300;
   localparam logic [11:0]     CSR_MEPC    = 12'h341;
   localparam logic [11:0]     CSR_MCAUSE  = 12'h342;
   localparam logic [11:0]     CSR_MTVAL   = 12'h343;
   localparam logic [XLEN-1:0] ALIGN_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

   typedef enum logic [2:0] {
      IDLE, WR_EPC, WR_CAUSE, WR_TVAL, WR_STATUS, MRET_ST, REDIRECT
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   epc_q;
   logic [XLEN-1:0]   ecause_q;
   logic [XLEN-1:0]   etval_q;
   logic [XLEN-1:0]   target_q;

   logic              in_except;
   logic [XLEN-1:0]   in_epc;
   logic [XLEN-1:0]   in_ecause;
   logic [XLEN-1:0]   in_etval;

   assign in_except = except_i[3*XLEN];
   assign in_epc    = except_i[3*XLEN-1:2*XLEN];
   assign in_ecause = except_i[2*XLEN-1:XLEN];
   assign in_etval  = except_i[XLEN-1:0];

   // Interrupt causes (MSB set) index into the vector table when mtvec selects vectored mode.
   logic              use_vector;
   logic [XLEN-1:0]   trap_base;
   logic [XLEN-1:0]   trap_target;

   assign use_vector  = VECTORED_EN && (mtvec_i[1:0] == 2'b01) && ecause_q[XLEN-1];
   assign trap_base   = mtvec_i & ALIGN_MASK;
   assign trap_target = use_vector ? trap_base + {ecause_q[XLEN-3:0], 2'b00} : trap_base;

   logic [XLEN-1:0]   status_trap;
   logic [XLEN-1:0]   status_mret;

   always_comb begin
      status_trap        = mstatus_i;
      status_trap[7]     = mstatus_i[3];
      status_trap[3]     = 1'b0;
      status_trap[12:11] = 2'b11;
      status_mret        = mstatus_i;
      status_mret[3]     = mstatus_i[7];
      status_mret[7]     = 1'b1;
      status_mret[12:11] = 2'b11;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         epc_q    <= '0;
         ecause_q <= '0;
         etval_q  <= '0;
         target_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Exception takes priority; a same-cycle mret is dropped with the flush.
               if (in_except) begin
                  epc_q    <= in_epc;
                  ecause_q <= in_ecause;
                  etval_q  <= in_etval;
                  state    <= WR_EPC;
               end else if (mret_i) begin
                  state    <= MRET_ST;
               end
            end
            WR_EPC:    state <= WR_CAUSE;
            WR_CAUSE:  state <= WR_TVAL;
            WR_TVAL:   state <= WR_STATUS;
            WR_STATUS: begin
               target_q <= trap_target;
               state    <= REDIRECT;
            end
            MRET_ST: begin
               target_q <= mepc_i & ALIGN_MASK;
               state    <= REDIRECT;
            end
            REDIRECT:  state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   // Moore decode: outputs depend only on registered state/pack (and live mstatus for its RMW).
   always_comb begin
      csr_we_o      = 1'b0;
      csr_waddr_o   = '0;
      csr_wdata_o   = '0;
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
      flush_o       = (state != IDLE);
      stall_o       = (state != IDLE);
      case (state)
         WR_EPC: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MEPC;
            csr_wdata_o = epc_q & ALIGN_MASK;
         end
         WR_CAUSE: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MCAUSE;
            csr_wdata_o = ecause_q;
         end
         WR_TVAL: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MTVAL;
            csr_wdata_o = etval_q;
         end
         WR_STATUS: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MSTATUS;
            csr_wdata_o = status_trap;
         end
         MRET_ST: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MSTATUS;
            csr_wdata_o = status_mret;
         end
         REDIRECT: begin
            redirect_o    = 1'b1;
            redirect_pc_o = target_q;
         end
         default: ;
      endcase
   end

endmodule
